// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants.
// Imported by the pipeline/state register slice.
package mips_pkg;

    typedef logic [31:0] word_t;

    localparam word_t WORD_RESET = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/flopenr_bit.sv
// Single-bit flop with synchronous active-low reset and load enable.
// Reset wins over enable; with enable low the bit holds.
module flopenr_bit #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : flopenr_bit

// File: rtl/flopenr_32.sv
// Enabled pipeline/state register built from per-bit flops.
// q comes straight from flops; no input-to-output path.
module flopenr_32
    import mips_pkg::*;
#(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VALUE = WIDTH'(WORD_RESET)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (WIDTH < 1) begin : g_bad_width
        $error("flopenr_32: WIDTH must be at least 1");
    end

    // Each bit gets its own reset value so non-zero patterns work too.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        flopenr_bit #(
            .RESET_VALUE(RESET_VALUE[i])
        ) u_bit (
            .clk  (clk),
            .reset(reset),
            .en   (en),
            .d    (d[i]),
            .q    (q[i])
        );
    end

endmodule : flopenr_32

// File: tb/tb_flopenr_32.sv
// Self-checking bench for flopenr_32: directed vectors,
// a behavioural reference, and a per-cycle comparator.
module tb_flopenr_32;
    import mips_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  en;
    word_t d;
    word_t q;

    int n_cmp = 0;
    int n_bad = 0;

    word_t model_q;
    bit    model_valid = 1'b0;

    flopenr_32 #(
        .WIDTH      (32),
        .RESET_VALUE(WORD_RESET)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .d    (d),
        .q    (q)
    );

    always #5 clk = ~clk;

    // Reference: register contents after each edge, from the priority rules.
    always @(posedge clk) begin
        if (reset === 1'b0) begin
            model_q     = 32'h0;
            model_valid = 1'b1;
        end else if (en === 1'b1) begin
            model_q = d;
        end
    end

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // q must match the reference in the middle of every cycle.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("per_cycle", q, model_q);
        end
    end

    task automatic step(input logic r, input logic e, input word_t dv);
        @(negedge clk);
        reset = r;
        en    = e;
        d     = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        d     = '0;

        step(1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("preload_ones", q, 32'hFFFF_FFFF);

        step(1'b0, 1'b1, 32'h1234_5678);
        chk("reset_clears", q, 32'h0000_0000);

        step(1'b1, 1'b1, 32'hDEAD_BEEF);
        chk("enabled_load", q, 32'hDEAD_BEEF);

        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 32'h0000_0001);
            chk("hold_disabled", q, 32'hDEAD_BEEF);
        end

        step(1'b1, 1'b1, 32'hA5A5_A5A5);
        chk("load_a5", q, 32'hA5A5_A5A5);
        step(1'b0, 1'b1, 32'h5A5A_5A5A);
        chk("reset_over_en", q, 32'h0000_0000);
        step(1'b1, 1'b1, 32'h5A5A_5A5A);
        chk("release_load", q, 32'h5A5A_5A5A);

        // Inputs wiggle between edges but are idle at the edge.
        @(negedge clk);
        en = 1'b1;
        d  = 32'hCAFE_F00D;
        #2;
        chk("midcycle_d_en", q, 32'h5A5A_5A5A);
        en = 1'b0;
        d  = 32'h0;
        @(posedge clk);
        #1;
        chk("midcycle_edge", q, 32'h5A5A_5A5A);

        // Reset glitch that never overlaps an edge.
        @(negedge clk);
        #1 reset = 1'b0;
        #2 reset = 1'b1;
        chk("reset_glitch_mid", q, 32'h5A5A_5A5A);
        @(posedge clk);
        #1;
        chk("reset_glitch_edge", q, 32'h5A5A_5A5A);

        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b1, 32'h1 << i);
            chk("walking_one", q, 32'h1 << i);
        end

        step(1'b0, 1'b0, 32'h7777_7777);
        chk("reset_pulse", q, 32'h0000_0000);
        step(1'b1, 1'b0, 32'hFFFF_FFFF);
        chk("stay_zero", q, 32'h0000_0000);
        step(1'b1, 1'b1, 32'h0F0F_0F0F);
        chk("reload", q, 32'h0F0F_0F0F);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_flopenr_32
